// File: rtl/pwm_multi_if.sv
// Control, duty-write and PWM-output bundle for pwm_multi.
interface pwm_multi_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int CSW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                en;
    logic                center;
    logic                wr;
    logic [CSW-1:0]      ch_sel;
    logic [WIDTH-1:0]    duty_in;
    logic [CHANNELS-1:0] pwm;
    logic                period_start;

    modport master (output en, center, wr, ch_sel, duty_in, input pwm, period_start);
    modport slave  (input en, center, wr, ch_sel, duty_in, output pwm, period_start);
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaler and chunk counter, edge/center alignment,
// shadowed duty registers that reload only at period boundaries.
module pwm_multi #(
    parameter int CLOCK    = 50000000,
    parameter int FREQ     = 100,
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic       clk,
    input  logic       clr,
    pwm_multi_if.slave bus
);
    localparam int CHUNK_SIZE = CLOCK / FREQ / (2 ** WIDTH);
    localparam int PW         = (CHUNK_SIZE > 2) ? $clog2(CHUNK_SIZE) : 1;
    localparam int CSW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}};
    localparam logic [PW-1:0]    PRE_LAST = PW'(CHUNK_SIZE - 1);

    if (CHUNK_SIZE < 2) begin : g_chunk_chk
        $error("pwm_multi: CLOCK/FREQ/2**WIDTH must be at least 2");
    end

    typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} dir_t;

    logic [PW-1:0]                  r_pre, w_pre_nxt;
    logic [WIDTH-1:0]               r_count, w_count_nxt;
    dir_t                           r_dir, w_dir_nxt;
    logic                           r_mode;
    logic                           r_ps;
    logic [CHANNELS-1:0][WIDTH-1:0] r_shadow, r_active;
    logic [CHANNELS-1:0]            r_pwm;
    logic [CHANNELS-1:0]            w_wr_hit;
    logic                           w_tick, w_bnd, w_load;

    assign w_tick = bus.en && (r_pre == PRE_LAST);
    assign w_bnd  = w_tick && (r_mode ? (r_count == WIDTH'(1) && r_dir == DIR_DN)
                                      : (r_count == MAX));
    // While disabled the active duties and mode follow their shadows every cycle
    assign w_load = !bus.en || w_bnd;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_pre   <= '0;
            r_count <= '0;
            r_dir   <= DIR_UP;
            r_mode  <= 1'b0;
            r_ps    <= 1'b0;
        end else begin
            r_pre   <= w_pre_nxt;
            r_count <= w_count_nxt;
            r_dir   <= w_dir_nxt;
            r_ps    <= w_bnd;
            if (w_load) r_mode <= bus.center;
        end
    end

    always_comb begin
        w_pre_nxt   = w_tick ? '0 : r_pre + PW'(1);
        w_count_nxt = r_count;
        w_dir_nxt   = r_dir;
        if (!bus.en) begin
            w_pre_nxt   = '0;
            w_count_nxt = '0;
            w_dir_nxt   = DIR_UP;
        end else if (w_bnd) begin
            // every period, and every mode change, restarts at 0 counting up
            w_count_nxt = '0;
            w_dir_nxt   = DIR_UP;
        end else if (w_tick) begin
            if (r_mode && r_dir == DIR_DN) begin
                w_count_nxt = r_count - WIDTH'(1);
            end else if (r_mode && r_count == MAX) begin
                w_count_nxt = MAX - WIDTH'(1);
                w_dir_nxt   = DIR_DN;
            end else begin
                w_count_nxt = r_count + WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_wr_hit = '0;
        for (int i = 0; i < CHANNELS; i++)
            w_wr_hit[i] = bus.wr && (bus.ch_sel == CSW'(i));
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_shadow <= '0;
            r_active <= '0;
            r_pwm    <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_wr_hit[i]) r_shadow[i] <= bus.duty_in;
                // a write landing on the reload edge goes straight to the active copy
                if (w_load) r_active[i] <= w_wr_hit[i] ? bus.duty_in : r_shadow[i];
                r_pwm[i] <= bus.en && (r_count < r_active[i]);
            end
        end
    end

    assign bus.pwm          = r_pwm;
    assign bus.period_start = r_ps;
endmodule
